// File: rtl/fma_pkg.sv
// Shared constants for the FMA pipeline controller.
//   FMA_EXP_W / FMA_MANT_W / FMA_TAG_W : default datapath format and tag widths
//   NUM_STG                            : fixed pipeline depth
//   STG_*                              : stage indices (CSA, GrandAdder, normalize, round)
package fma_pkg;
  localparam int FMA_EXP_W  = 8;
  localparam int FMA_MANT_W = 23;
  localparam int FMA_TAG_W  = 4;
  localparam int NUM_STG    = 4;
  localparam int STG_CSA    = 0;
  localparam int STG_ADD    = 1;
  localparam int STG_NORM   = 2;
  localparam int STG_RND    = 3;
endpackage

// File: rtl/fma_ctrl_stage.sv
// One controller stage: valid bit plus the tag/special sideband of the op it holds.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : drop the held op (wins over en_i)
//   en_i          : stage advances this edge (takes vld_i/tag_i/spc_i)
//   vld_i, tag_i, spc_i : contents of the preceding stage (or the input port)
//   vld_o, tag_o, spc_o : registered stage contents
module fma_ctrl_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             spc_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             spc_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o <= 1'b0;
      tag_o <= '0;
      spc_o <= 1'b0;
    end else if (flush_i) begin
      vld_o <= 1'b0;
    end else if (en_i) begin
      vld_o <= vld_i;
      tag_o <= tag_i;
      spc_o <= spc_i;
    end
  end
endmodule

// File: rtl/fma_pipe_ctrl.sv
// Control for a fixed 4-stage in-order FMA pipeline (CSA, GrandAdder, normalize,
// round/output) with valid/ready handshakes, bubble collapsing and flush.
//   clk_i, rst_ni              : clock, async active-low reset
//   In_valid_i / In_ready_o    : input handshake, Tag_i / Special_i ride along
//   Flush_i                    : discard every in-flight op
//   Out_valid_o / Out_ready_i  : output handshake on S3, Tag_o / Special_o
//   Stage_ld_o                 : datapath register load enables per stage
//   Stage_valid_o, Occupancy_o : per-stage valid bits and their count
module fma_pipe_ctrl
  import fma_pkg::*;
#(
  parameter int PARM_EXP  = FMA_EXP_W,
  parameter int PARM_MANT = FMA_MANT_W,
  parameter int PARM_TAG  = FMA_TAG_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                In_valid_i,
  output logic                In_ready_o,
  input  logic [PARM_TAG-1:0] Tag_i,
  input  logic                Special_i,
  input  logic                Flush_i,
  output logic                Out_valid_o,
  input  logic                Out_ready_i,
  output logic [PARM_TAG-1:0] Tag_o,
  output logic                Special_o,
  output logic [NUM_STG-1:0]  Stage_ld_o,
  output logic [NUM_STG-1:0]  Stage_valid_o,
  output logic [2:0]          Occupancy_o
);
  // Format widths only configure the datapath; reject degenerate formats early.
  if (PARM_EXP < 2 || PARM_MANT < 1 || PARM_TAG < 1) begin : g_bad_cfg
    $error("fma_pipe_ctrl: unsupported format/tag widths");
  end

  logic [NUM_STG-1:0]               v, en, vin;
  logic [NUM_STG-1:0][PARM_TAG-1:0] tag_q, tag_in;
  logic [NUM_STG-1:0]               spc_q, spc_in;
  logic                             acc, hs;
  logic [2:0]                       occ_q;

  // A stage may advance if it or any stage downstream of it is empty, or the
  // output is being drained. Closed form avoids a ripple through en itself.
  for (genvar k = 0; k < NUM_STG; k++) begin : g_en
    assign en[k] = ~(&v[NUM_STG-1:k]) | Out_ready_i;
  end

  // Gated by rst_ni so nothing is offered or loaded while reset is held.
  assign In_ready_o = en[STG_CSA] & ~Flush_i & rst_ni;
  assign acc        = In_valid_i & In_ready_o;
  assign hs         = v[STG_RND] & Out_ready_i;
  assign vin        = {v[STG_NORM], v[STG_ADD], v[STG_CSA], acc};
  assign Stage_ld_o = en & vin;

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    if (k == STG_CSA) begin : g_head
      assign tag_in[k] = Tag_i;
      assign spc_in[k] = Special_i;
    end else begin : g_body
      assign tag_in[k] = tag_q[k-1];
      assign spc_in[k] = spc_q[k-1];
    end

    fma_ctrl_stage #(.TAG_W(PARM_TAG)) u_stg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (Flush_i),
      .en_i    (en[k]),
      .vld_i   (vin[k]),
      .tag_i   (tag_in[k]),
      .spc_i   (spc_in[k]),
      .vld_o   (v[k]),
      .tag_o   (tag_q[k]),
      .spc_o   (spc_q[k])
    );
  end

  // Tracks popcount(v) incrementally rather than adding the bits each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          occ_q <= '0;
    else if (Flush_i)     occ_q <= '0;
    else if (acc && !hs)  occ_q <= occ_q + 3'd1;
    else if (hs && !acc)  occ_q <= occ_q - 3'd1;
  end

  assign Out_valid_o   = v[STG_RND];
  assign Tag_o         = tag_q[STG_RND];
  assign Special_o     = spc_q[STG_RND];
  assign Stage_valid_o = v;
  assign Occupancy_o   = occ_q;
endmodule

// File: tb/tb_fma_pipe_ctrl.sv
module tb_fma_pipe_ctrl;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, special = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [TW-1:0] tag = '0;
  logic          in_ready, out_valid, special_o;
  logic [TW-1:0] tag_o;
  logic [3:0]    stage_ld, stage_valid;
  logic [2:0]    occ;

  always #5 clk = ~clk;

  fma_pipe_ctrl #(.PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .In_valid_i(in_valid), .In_ready_o(in_ready),
    .Tag_i(tag), .Special_i(special), .Flush_i(flush), .Out_valid_o(out_valid),
    .Out_ready_i(out_ready), .Tag_o(tag_o), .Special_o(special_o),
    .Stage_ld_o(stage_ld), .Stage_valid_o(stage_valid), .Occupancy_o(occ)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference: in-order list of ops in flight, each with the stage it sits in.
  // Each edge the oldest op leaves if it is in S3 and downstream is ready; every
  // other op moves one stage forward unless the op ahead of it blocks the slot.
  typedef struct {logic [TW-1:0] tag; logic spc; int pos;} op_t;
  op_t q[$];
  int  np[$];
  bit  pop, room, acc_m;

  task automatic plan(input bit ordy);
    int lim;
    np.delete();
    pop = (q.size() > 0) && (q[0].pos == 3) && ordy;
    lim = 3;
    foreach (q[i]) begin
      if (i == 0 && pop) np.push_back(-1);
      else begin
        np.push_back((q[i].pos + 1 < lim) ? q[i].pos + 1 : lim);
        lim = np[i] - 1;
      end
    end
    room = (q.size() == 0) || (np[q.size()-1] != 0);
  endtask

  task automatic check_outs();
    bit   exp_rdy, ov;
    int   sv, ld;
    plan(out_ready);
    exp_rdy = rst_n && !flush && room;
    acc_m   = in_valid && exp_rdy;
    ov      = (q.size() > 0) && (q[0].pos == 3);
    sv = 0; ld = 0;
    foreach (q[i]) begin
      sv |= 1 << q[i].pos;
      if (np[i] >= 0 && np[i] != q[i].pos) ld |= 1 << np[i];
    end
    if (acc_m) ld |= 1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(ov));
    if (ov) begin
      chk("tag_o", 32'(tag_o), 32'(q[0].tag));
      chk("special_o", 32'(special_o), 32'(q[0].spc));
    end
    chk("stage_valid", 32'(stage_valid), 32'(sv));
    chk("occupancy", 32'(occ), 32'(q.size()));
    chk("stage_ld", 32'(stage_ld), 32'(ld));
  endtask

  task automatic update();
    op_t nq[$];
    op_t o;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      foreach (q[i]) if (np[i] >= 0) begin
        o = q[i]; o.pos = np[i]; nq.push_back(o);
      end
      if (acc_m) nq.push_back('{tag: tag, spc: special, pos: 0});
      q = nq;
    end
  endtask

  // One clock: drive inputs, check between edges, advance the model at the edge.
  task automatic cyc(input bit iv, input logic [TW-1:0] tg, input bit sp,
                     input bit fl, input bit ordy, output bit accepted);
    in_valid = iv; tag = tg; special = sp; flush = fl; out_ready = ordy;
    @(negedge clk);
    check_outs();
    accepted = acc_m;
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, ordy, a);
  endtask

  initial begin
    bit a;
    logic [TW-1:0] t;
    // reset held
    idle(2, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single op, tag 0x5
    cyc(1, 4'h5, 0, 0, 1, a);
    idle(6, 1);

    // 8 back-to-back ops, tags 0..7
    for (int i = 0; i < 8; i++) cyc(1, 4'(i), 0, 0, 1, a);
    idle(5, 1);

    // backpressure from cycle 4 while still streaming, then release
    t = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, t, 0, 0, (i < 4), a);
      if (a) t++;
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1, t, 0, 0, 1, a);
      if (a) t++;
    end
    idle(5, 1);

    // flush with an op offered in the same cycle
    for (int i = 0; i < 2; i++) cyc(1, 4'(8 + i), 0, 0, 1, a);
    cyc(1, 4'hA, 0, 0, 0, a);
    cyc(1, 4'hB, 0, 1, 1, a);
    idle(5, 1);

    // async reset with two ops in flight
    cyc(1, 4'h3, 0, 0, 1, a);
    cyc(1, 4'h4, 1, 0, 1, a);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stage_valid", 32'(stage_valid), 32'd0);
    chk("rst_occupancy", 32'(occ), 32'd0);
    chk("rst_stage_ld", 32'(stage_ld), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_tag_o", 32'(tag_o), 32'd0);
    @(posedge clk); #1;
    idle(1, 1);
    rst_n = 1'b1;
    cyc(1, 4'hC, 1, 0, 1, a);
    idle(6, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, 4'($urandom), 1'($urandom), ($urandom % 32) == 0,
          ($urandom % 10) < 7, a);
    idle(6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
